serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor: computes a − b one bit per clock as a + ~b + 1, LSB first.
- Uses a single full-adder slice and a carry flip-flop.
- Companion to the combinational ripple adder/subtractor. It is the area-minimal subtract path for the ALU and produces the same carryout/overflow flag semantics.
- Start/busy/done handshake toward the ALU control.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first as a + ~b + 1
// through one full-adder slice. Optional signed-less-than flag under SERIAL_SUB_SLT_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
`ifdef SERIAL_SUB_SLT_EN
  ,
  output logic             slt
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from the slice on the last edge.
  logic [WIDTH-2:0] r_sh;
  logic [CW-1:0]    count;
  logic             carry;
  logic             cmsb_in;

  logic             s;
  logic             c;

  always_comb begin
    s = a_sh[0] ^ b_sh[0] ^ carry;
    c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
`ifdef SERIAL_SUB_SLT_EN
      slt      <= 1'b0;
`endif
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      count    <= '0;
      carry    <= 1'b0;
      cmsb_in  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= ~b;
            carry <= 1'b1;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= (r_sh >> 1) | ((WIDTH - 1)'(s) << (WIDTH - 2));
          carry <= c;
          count <= count + 1'b1;
          if (count == MSB_M1) begin
            cmsb_in <= c;
          end
          if (count == LAST_BIT) begin
            result   <= {s, r_sh};
            carryout <= c;
            overflow <= cmsb_in ^ c;
`ifdef SERIAL_SUB_SLT_EN
            slt      <= s ^ cmsb_in ^ c;
`endif
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 4.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
`ifdef SERIAL_SUB_SLT_EN
  logic         slt;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carryout (carryout),
    .overflow (overflow)
`ifdef SERIAL_SUB_SLT_EN
    ,
    .slt      (slt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    logic         lt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [W-1:0] res, input logic co,
                             input logic ov, input logic lt);
    chk({tag, " result"}, 32'(result), 32'(res));
    chk({tag, " carryout"}, 32'(carryout), 32'(co));
    chk({tag, " overflow"}, 32'(overflow), 32'(ov));
`ifdef SERIAL_SUB_SLT_EN
    chk({tag, " slt"}, 32'(slt), 32'(lt));
`else
    if (lt === 1'bx) chk({tag, " slt"}, 32'(lt), 32'(0));
`endif
  endtask

  // Start an operation, then check done latency, busy length, single-cycle done and flags.
  task automatic run_op(input string tag, input vec_t v);
    int edges;
    int busy_cycles;
    bit seen;
    @(negedge clk);
    a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~v.a; b = ~v.b;
    busy_cycles = busy ? 1 : 0;
    edges = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, " done seen"}, 32'(seen), 32'(1));
    chk({tag, " done latency"}, 32'(edges), 32'(W));
    chk({tag, " busy cycles"}, 32'(busy_cycles), 32'(W));
    check_flags(tag, v.res, v.co, v.ov, v.lt);
    @(posedge clk); #1;
    chk({tag, " done width"}, 32'(done), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    check_flags({tag, " hold"}, v.res, v.co, v.ov, v.lt);
  endtask

  vec_t vecs[6];

  initial begin
    int dones;
    int busy_cycles;
    bit seen;

    vecs[0] = '{a: 4'b0101, b: 4'b0011, res: 4'b0010, co: 1'b1, ov: 1'b0, lt: 1'b0};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, res: 4'b1110, co: 1'b0, ov: 1'b0, lt: 1'b1};
    vecs[2] = '{a: 4'b0100, b: 4'b1000, res: 4'b1100, co: 1'b0, ov: 1'b1, lt: 1'b0};
    vecs[3] = '{a: 4'b1000, b: 4'b0001, res: 4'b0111, co: 1'b1, ov: 1'b1, lt: 1'b1};
    vecs[4] = '{a: 4'b1010, b: 4'b1010, res: 4'b0000, co: 1'b1, ov: 1'b0, lt: 1'b0};
    vecs[5] = '{a: 4'b1001, b: 4'b0000, res: 4'b1001, co: 1'b1, ov: 1'b0, lt: 1'b1};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    check_flags("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Garbage operands and repeated start pulses during SHIFT and DONE must be ignored.
    @(negedge clk);
    a = 4'b0111; b = 4'b0010; start = 1'b1;
    @(posedge clk); #1;
    a = 4'b1111; b = 4'b1111;
    busy_cycles = busy ? 1 : 0;
    dones = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        seen = 1;
      end
    end
    chk("ignore done seen", 32'(seen), 32'(1));
    check_flags("ignore", 4'b0101, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
      if (done) dones++;
    end
    chk("ignore done count", 32'(dones), 32'(1));
    chk("ignore busy cycles", 32'(busy_cycles), 32'(W));
    check_flags("ignore hold", 4'b0101, 1'b1, 1'b0, 1'b0);

    // Reset at edge 2 of an operation aborts it with no done pulse.
    @(negedge clk);
    a = 4'b0110; b = 4'b0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    @(posedge clk); #1;
    if (done) dones++;
    reset = 1'b1;
    @(posedge clk); #1;
    if (done) dones++;
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    check_flags("abort", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort no done", 32'(dones), 32'(0));
    run_op("after abort", '{a: 4'b0110, b: 4'b0001, res: 4'b0101, co: 1'b1, ov: 1'b0, lt: 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
